imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Fetch sequencer for the byte-addressed, combinational-read instruction memory. Owns the program counter, drives the memory address, and captures each 32-bit little-endian word into a one-entry output register. Presents the word to the IF/ID stage over a valid/ready handshake. Handles branch redirects from EX, back-pressure from ID stalls, and a terminal halt on out-of-range or all-zero fetches.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded at reset.
- IMEM_BYTES, 88, instruction memory size in bytes. A fetch is legal only if pc + 4 <= IMEM_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching.
- imem_addr  out  64  memory byte address. Always equals the pc register.
- imem_instr  in  32  combinational read data for imem_addr.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  64  redirect target.
- out_valid  out  1  out_instr/out_pc hold a fetched word.
- out_ready  in  1  IF/ID accepts the word this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  64  address of out_instr.
- halted  out  1  controller is in HALT.
- fetch_count  out  32  count of accepted words, saturating.
- misaligned  out  1  misaligned redirect seen. Present only with FETCH_MISALIGN_TRAP_EN.

## Operation
- The FSM has three states: IDLE, RUN, HALT.
  - IDLE -> RUN when start = 1.
  - RUN -> HALT on an illegal fetch or a zero word.
  - HALT exits only via reset.
- A slot is free when out_valid = 0 or (out_valid & out_ready) = 1.
- RUN cycle priority, highest first:
  1. redirect_valid: pc <= redirect_pc, out_valid <= 0 (flush), no capture.
  2. Slot free and pc + 4 > IMEM_BYTES: enter HALT and clear out_valid after any handshake; no capture.
  3. Slot free and imem_instr == 32'h0: enter HALT; the word is not captured.
  4. Slot free otherwise: out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc + 4.
  5. Slot not free: everything holds (stall).
- An entry held in the output register when the controller enters HALT stays valid until it is accepted. After that, out_valid stays 0.
- In IDLE and HALT, redirect_valid and start are ignored.
- fetch_count increments on every out_valid & out_ready cycle and saturates at 32'hFFFF_FFFF.
- PC arithmetic is 64-bit modulo. The legality check uses a 65-bit sum so wrap-around is never treated as legal.

## Timing
- Reset values: state IDLE, pc = RESET_PC, out_valid 0, out_instr 0, out_pc 0, halted 0, fetch_count 0, misaligned 0.
- imem_addr is registered (pc) and the read is combinational, so a capture lands in the same cycle and out_valid rises the cycle after the slot frees.
- With out_ready held high, throughput is one word per cycle.
- After start is sampled, the first out_valid appears two cycles later: one cycle for IDLE -> RUN, one cycle to capture.
- A redirect in cycle N means the target word is valid at N+2. A word accepted in cycle N (ready & valid while redirect is high) still counts.
- Reset asserted mid-operation overrides everything in the same edge.
- halted rises on the edge that enters HALT.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the output register, sets misaligned (sticky until reset) and enters HALT.
  - pc is not updated.
- FETCH_MISALIGN_TRAP_EN undefined:
  - The misaligned port is absent.
  - redirect_pc[1:0] is forced to 2'b00 on load.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, RUN, HALT);
  - constants INSTR_BYTES = 4 and ZERO_INSTR = 32'h0.
- One sub-module, fetch_out_reg: the one-entry valid/ready holding register with a flush input. The PC/FSM logic stays in the top.

## Test plan
- Reset then start, with RESET_PC = 4, mem[4..7] = 0x009A84B3, mem[8..11] = 0x00148493, mem[12..15] = 0, out_ready = 1:
  - outputs (0x009A84B3, pc 4) then (0x00148493, pc 8);
  - then HALT, halted = 1, fetch_count = 2.
- Hold out_ready = 0 for 3 cycles after the first valid: out_instr and out_pc stay stable, pc stays 8, fetch_count stays 0 until the release.
- redirect_valid with redirect_pc = 4 while out_valid = 1 and out_ready = 0:
  - out_valid drops next cycle;
  - pc 4 is re-fetched and valid two cycles after the redirect.
- pc = 84 with IMEM_BYTES = 88: word at 84 is delivered, next fetch at 88 enters HALT, imem_addr holds 88.
- Reset asserted while out_valid = 1 in RUN: next cycle out_valid = 0, pc = RESET_PC, state IDLE, fetch_count = 0.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc = 6: misaligned = 1, halted = 1, no further valid output.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller: FSM state encoding
// and the fetch granularity / terminating-word constants.
// Optional feature macro used by the controller: FETCH_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] ZERO_INSTR  = 32'h0;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_out_reg.sv
// -----------------------------------------------------------------------------
// fetch_out_reg
// One-entry valid/ready holding register between fetch and IF/ID.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   flush_i         - drop the held entry (highest priority)
//   capture_i       - load instr_i/pc_i and mark the entry valid
//   instr_i, pc_i   - word and its address to capture
//   ready_i         - consumer accepts the entry this cycle
//   valid_o         - entry is valid
//   instr_o, pc_o   - held word and its address
//   slot_free_o     - entry empty or being accepted this cycle
// -----------------------------------------------------------------------------
module fetch_out_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        capture_i,
    input  logic [31:0] instr_i,
    input  logic [63:0] pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        slot_free_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [63:0] pc_q;

    assign slot_free_o = !valid_q || ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (capture_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (valid_q && ready_i) begin
            // Accepted with nothing to replace it: the slot empties.
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer for a byte-addressed, combinational-read instruction memory.
// Owns the PC, drives the memory address, captures each 32-bit word into a
// one-entry output register and hands it to IF/ID over valid/ready. Handles
// branch redirects, ID back-pressure and a terminal halt on an out-of-range
// or all-zero fetch.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start                       - leave IDLE and begin fetching
//   imem_addr / imem_instr      - memory address (the PC) / read data
//   redirect_valid/redirect_pc  - branch/jump redirect from EX
//   out_valid/out_ready         - handshake towards IF/ID
//   out_instr/out_pc            - fetched word and its address
//   halted                      - controller is in HALT
//   fetch_count                 - accepted words, saturating
//   misaligned                  - sticky misaligned-redirect flag
// Macro FETCH_MISALIGN_TRAP_EN: when defined, a misaligned redirect traps
// into HALT and the misaligned port exists; otherwise the target is aligned
// down on load and the port is absent.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 88
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        halted,
    output logic [31:0] fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  count_q;
    logic         capture, flush, slot_free;
    logic [64:0]  fetch_end;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         mis_q, mis_d;
`endif

    // 65-bit end address so a PC near the top of the space cannot wrap into
    // an apparently legal fetch.
    assign fetch_end = {1'b0, pc_q} + 65'(INSTR_BYTES);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        flush   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = redirect_pc;
                    end
`else
                    pc_d = redirect_pc & ~64'h3;
`endif
                end else if (slot_free) begin
                    if (fetch_end > 65'(IMEM_BYTES)) begin
                        state_d = HALT;
                    end else if (imem_instr == ZERO_INSTR) begin
                        state_d = HALT;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + 64'(INSTR_BYTES);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (out_valid && out_ready && (count_q != 32'hFFFF_FFFF))
                count_q <= count_q + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Entering HALT needs no explicit clear: HALT is only entered with the
    // slot free, so any held word is already being accepted that cycle.
    fetch_out_reg u_out (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .capture_i   (capture),
        .instr_i     (imem_instr),
        .pc_i        (pc_q),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .instr_o     (out_instr),
        .pc_o        (out_pc),
        .slot_free_o (slot_free)
    );

    assign imem_addr   = pc_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned  = mis_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    localparam int          BYTES = 88;
    localparam logic [63:0] RPC   = 64'd4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    logic [7:0] mem [0:BYTES-1];
    logic [6:0] ia;

    assign ia = imem_addr[6:0];
    assign imem_instr = (imem_addr <= 64'(BYTES - 4)) ?
        {mem[ia + 7'd3], mem[ia + 7'd2], mem[ia + 7'd1], mem[ia]} : 32'hDEAD_BEEF;

    imem_fetch_ctrl #(.RESET_PC(RPC), .IMEM_BYTES(BYTES)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned     (misaligned)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_mode;
    bit          m_has;
    logic [31:0] m_instr;
    logic [63:0] m_opc;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [63:0] a);
        int i;
        if (a > 64'(BYTES - 4)) return 32'hDEAD_BEEF;
        i = int'(a);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    task automatic setword(input int a, input logic [31:0] w);
        {mem[a+3], mem[a+2], mem[a+1], mem[a]} = w;
    endtask

    task automatic model_step();
        bit acc;
        if (reset) begin
            m_mode = M_IDLE; m_has = 0; m_instr = '0; m_opc = '0;
            m_pc = RPC; m_cnt = '0; m_mis = 0;
        end else begin
            acc = m_has && out_ready;
            if (acc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_mode == M_IDLE) begin
                if (start) m_mode = M_RUN;
            end else if (m_mode == M_HALT) begin
                if (acc) m_has = 0;
            end else if (redirect_valid) begin
                m_has = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (redirect_pc % 4 != 0) begin
                    m_mis  = 1;
                    m_mode = M_HALT;
                end else begin
                    m_pc = redirect_pc;
                end
`else
                m_pc = redirect_pc - (redirect_pc % 4);
`endif
            end else if (m_has && !acc) begin
                // stall
            end else if (m_pc > 64'(BYTES - 4)) begin
                m_mode = M_HALT; m_has = 0;
            end else if (memword(m_pc) == 32'h0) begin
                m_mode = M_HALT; m_has = 0;
            end else begin
                m_has = 1; m_instr = memword(m_pc); m_opc = m_pc; m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, m_has);
        if (m_has) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_pc", out_pc, m_opc);
        end
        chk("imem_addr", imem_addr, m_pc);
        chk("halted", halted, m_mode == M_HALT);
        chk("fetch_count", fetch_count, m_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misaligned", misaligned, m_mis);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        reset = 1; start = 0; redirect_valid = 0;
        cycle();
        reset = 0;
    endtask

    task automatic load_prog();
        for (int a = 0; a < BYTES; a += 4) setword(a, 32'h0000_0013);
        setword(4, 32'h009A_84B3);
        setword(8, 32'h0014_8493);
        setword(12, 32'h0);
    endtask

    logic [31:0] w;

    initial begin
        load_prog();

        // Basic run: two words then halt on the zero word.
        do_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_addr", imem_addr, 64'd4);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_count", fetch_count, 32'd0);
        out_ready = 1; start = 1;
        cycle();
        start = 0;
        chk("idle2run_valid", out_valid, 1'b0);
        cycle();
        chk("w0_valid", out_valid, 1'b1);
        chk("w0_instr", out_instr, 32'h009A_84B3);
        chk("w0_pc", out_pc, 64'd4);
        cycle();
        chk("w1_instr", out_instr, 32'h0014_8493);
        chk("w1_pc", out_pc, 64'd8);
        chk("w1_count", fetch_count, 32'd1);
        cycle();
        chk("zero_halted", halted, 1'b1);
        chk("zero_valid", out_valid, 1'b0);
        chk("zero_count", fetch_count, 32'd2);
        cycle();
        chk("halt_sticky", halted, 1'b1);

        // Back-pressure: hold out_ready low for three cycles.
        do_reset();
        out_ready = 0; start = 1;
        cycle();
        start = 0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_instr", out_instr, 32'h009A_84B3);
            chk("stall_pc", out_pc, 64'd4);
            chk("stall_addr", imem_addr, 64'd8);
            chk("stall_count", fetch_count, 32'd0);
        end
        out_ready = 1;
        cycle();
        chk("release_count", fetch_count, 32'd1);
        chk("release_pc", out_pc, 64'd8);

        // Redirect while a word is held and not accepted.
        do_reset();
        out_ready = 0; start = 1;
        cycle();
        start = 0;
        cycle();
        redirect_valid = 1; redirect_pc = 64'd4;
        cycle();
        redirect_valid = 0;
        chk("redir_flush", out_valid, 1'b0);
        chk("redir_addr", imem_addr, 64'd4);
        cycle();
        chk("redir_valid", out_valid, 1'b1);
        chk("redir_pc", out_pc, 64'd4);

        // Last legal word at 84, then halt at 88.
        do_reset();
        out_ready = 1; start = 1;
        cycle();
        start = 0;
        redirect_valid = 1; redirect_pc = 64'd84;
        cycle();
        redirect_valid = 0;
        cycle();
        chk("end_pc", out_pc, 64'd84);
        chk("end_valid", out_valid, 1'b1);
        cycle();
        chk("end_halted", halted, 1'b1);
        chk("end_addr", imem_addr, 64'd88);
        chk("end_valid0", out_valid, 1'b0);

        // Reset while a word is held in RUN.
        do_reset();
        out_ready = 1; start = 1;
        cycle();
        start = 0;
        cycle();
        cycle();
        out_ready = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_addr", imem_addr, RPC);
        chk("mrst_count", fetch_count, 32'd0);
        cycle();
        chk("mrst_idle_addr", imem_addr, RPC);
        chk("mrst_idle_valid", out_valid, 1'b0);

        // Misaligned redirect target.
        do_reset();
        out_ready = 1; start = 1;
        cycle();
        start = 0;
        redirect_valid = 1; redirect_pc = 64'd6;
        cycle();
        redirect_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag", misaligned, 1'b1);
        chk("mis_halted", halted, 1'b1);
        chk("mis_addr", imem_addr, 64'd4);
        cycle();
        cycle();
        chk("mis_novalid", out_valid, 1'b0);
`else
        chk("align_addr", imem_addr, 64'd4);
        cycle();
        chk("align_pc", out_pc, 64'd4);
`endif

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 40; ep++) begin
            for (int a = 0; a < BYTES; a += 4) begin
                w = $urandom;
                if ($urandom_range(0, 11) == 0 || w == 32'h0) w = 32'h0;
                setword(a, w);
            end
            do_reset();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                redirect_valid = $urandom_range(0, 1) == 1;
                redirect_pc    = 64'($urandom_range(0, 20)) * 4;
                out_ready      = $urandom_range(0, 1) == 1;
                cycle();
            end
            start = 1;
            cycle();
            for (int k = 0; k < 30; k++) begin
                start          = $urandom_range(0, 3) == 0;
                out_ready      = $urandom_range(0, 3) != 0;
                redirect_valid = $urandom_range(0, 7) == 0;
                case ($urandom_range(0, 6))
                    0:       redirect_pc = 64'($urandom_range(0, 95));
                    1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC - 64'($urandom_range(0, 3)) * 4;
                    default: redirect_pc = 64'($urandom_range(0, 23)) * 4;
                endcase
                reset = $urandom_range(0, 59) == 0;
                cycle();
                reset = 0;
            end
            redirect_valid = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
